// File: rtl/top_alu_pkg.sv
// Shared widths and opcode encodings for the TP1 ALU.
// Opcodes follow the MIPS R-type funct field.
package top_alu_pkg;

  localparam int DEF_NB_DATA = 8;
  localparam int DEF_NB_OP   = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/top_alu_alu.sv
// Combinational signed ALU; unknown opcodes produce zero.
// Latency: none (pure logic). Backpressure: not applicable.
module alu
  import top_alu_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_OP   = DEF_NB_OP
) (
  input  logic [NB_DATA-1:0] data_a,
  input  logic [NB_DATA-1:0] data_b,
  input  logic [NB_OP-1:0]   op,
  output logic [NB_DATA-1:0] result
);

  localparam logic [NB_OP-1:0] L_ADD = NB_OP'(OP_ADD);
  localparam logic [NB_OP-1:0] L_SUB = NB_OP'(OP_SUB);
  localparam logic [NB_OP-1:0] L_AND = NB_OP'(OP_AND);
  localparam logic [NB_OP-1:0] L_OR  = NB_OP'(OP_OR);
  localparam logic [NB_OP-1:0] L_XOR = NB_OP'(OP_XOR);
  localparam logic [NB_OP-1:0] L_NOR = NB_OP'(OP_NOR);
  localparam logic [NB_OP-1:0] L_SRA = NB_OP'(OP_SRA);
  localparam logic [NB_OP-1:0] L_SRL = NB_OP'(OP_SRL);

  always_comb begin
    result = '0;
    case (op)
      L_ADD: result = data_a + data_b;
      L_SUB: result = data_a - data_b;
      L_AND: result = data_a & data_b;
      L_OR:  result = data_a | data_b;
      L_XOR: result = data_a ^ data_b;
      L_NOR: result = ~(data_a | data_b);
      // data_b is an unsigned amount; oversize shifts saturate to sign fill / zero
      L_SRA: result = $signed(data_a) >>> data_b;
      L_SRL: result = data_a >> data_b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/top_alu.sv
// Board wrapper: buttons load switch value into A, B or opcode; ALU result to LEDs.
// Latency: one edge from register load to o_led. Backpressure: none; loads gated by i_valid.
module top_alu
  import top_alu_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_OP   = DEF_NB_OP
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [2:0]         i_btn,
  input  logic [NB_DATA-1:0] i_sw_data,
  output logic [NB_DATA-1:0] o_led
);

  logic [NB_DATA-1:0] data_a;
  logic [NB_DATA-1:0] data_b;
  logic [NB_OP-1:0]   op;
  logic [NB_DATA-1:0] alu_result;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      data_a <= '0;
      data_b <= '0;
      op     <= '0;
      o_led  <= '0;
    end else begin
      if (i_valid) begin
        if (i_btn[0]) data_a <= i_sw_data;
        if (i_btn[1]) data_b <= i_sw_data;
        if (i_btn[2]) op     <= i_sw_data[NB_OP-1:0];
      end
      o_led <= alu_result;
    end
  end

  alu #(
    .NB_DATA (NB_DATA),
    .NB_OP   (NB_OP)
  ) u_alu (
    .data_a (data_a),
    .data_b (data_b),
    .op     (op),
    .result (alu_result)
  );

endmodule

// File: tb/tb_top_alu.sv
// Bench for top_alu: directed vector table, hand sequences for valid/reset, random vs reference model.
module tb_top_alu;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_valid;
  logic [2:0] i_btn;
  logic [7:0] i_sw_data;
  logic [7:0] o_led;

  int n_vec = 0;
  int n_bad = 0;

  // reference state
  logic [7:0] m_a, m_b;
  logic [5:0] m_op;
  logic [7:0] m_led;

  always #5 clk = ~clk;

  top_alu #(.NB_DATA(8), .NB_OP(6)) dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .i_btn     (i_btn),
    .i_sw_data (i_sw_data),
    .o_led     (o_led)
  );

  typedef struct {
    logic [2:0] btn;
    logic [7:0] sw;
    logic [7:0] exp;
  } vec_t;

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    int sa, sb, ua, ub, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    r  = 0;
    case (op)
      6'b100000: r = sa + sb;
      6'b100010: r = sa - sb;
      6'b100100: r = ua & ub;
      6'b100101: r = ua | ub;
      6'b100110: r = ua ^ ub;
      6'b100111: r = ~(ua | ub);
      6'b000011: r = (ub >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
      6'b000010: r = (ub >= 8) ? 0 : ua / (1 << ub);
      default:   r = 0;
    endcase
    return r[7:0];
  endfunction

  // One clock: drive at negedge, advance model at posedge, sample 1 time unit later.
  task automatic step(input logic rst, input logic vld, input logic [2:0] btn,
                      input logic [7:0] sw);
    @(negedge clk);
    i_rst     = rst;
    i_valid   = vld;
    i_btn     = btn;
    i_sw_data = sw;
    @(posedge clk);
    #1;
    if (rst) begin
      m_a = '0; m_b = '0; m_op = '0; m_led = '0;
    end else begin
      m_led = ref_alu(m_a, m_b, m_op);
      if (vld) begin
        if (btn[0]) m_a = sw;
        if (btn[1]) m_b = sw;
        if (btn[2]) m_op = sw[5:0];
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    n_vec++;
    if (o_led !== exp) begin
      n_bad++;
      $display("FAIL %s: o_led=0x%02h expected 0x%02h", name, o_led, exp);
    end
  endtask

  vec_t tbl[25];

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_btn = 3'b000; i_sw_data = 8'h00;
    m_a = '0; m_b = '0; m_op = '0; m_led = '0;

    // expected o_led after each edge, starting from reset state
    tbl[0]  = '{3'b001, 8'd15, 8'h00};
    tbl[1]  = '{3'b010, 8'd10, 8'h00};
    tbl[2]  = '{3'b100, 8'h20, 8'h00};
    tbl[3]  = '{3'b000, 8'h00, 8'd25};
    tbl[4]  = '{3'b100, 8'h22, 8'd25};
    tbl[5]  = '{3'b000, 8'h00, 8'd5};
    tbl[6]  = '{3'b100, 8'h24, 8'd5};
    tbl[7]  = '{3'b100, 8'h25, 8'd10};
    tbl[8]  = '{3'b100, 8'h26, 8'd15};
    tbl[9]  = '{3'b100, 8'h27, 8'd5};
    tbl[10] = '{3'b000, 8'h00, 8'hF0};
    tbl[11] = '{3'b001, 8'hF0, 8'hF0};
    tbl[12] = '{3'b010, 8'h02, 8'h05};
    tbl[13] = '{3'b100, 8'h03, 8'h0D};
    tbl[14] = '{3'b100, 8'h02, 8'hFC};
    tbl[15] = '{3'b010, 8'h09, 8'h3C};
    tbl[16] = '{3'b100, 8'h03, 8'h00};
    tbl[17] = '{3'b000, 8'h00, 8'hFF};
    tbl[18] = '{3'b001, 8'h7F, 8'hFF};
    tbl[19] = '{3'b010, 8'h01, 8'h00};
    tbl[20] = '{3'b100, 8'h20, 8'h3F};
    tbl[21] = '{3'b001, 8'h80, 8'h80};
    tbl[22] = '{3'b100, 8'h22, 8'h81};
    tbl[23] = '{3'b100, 8'h3F, 8'h7F};
    tbl[24] = '{3'b000, 8'h00, 8'h00};

    // reset with garbage loads requested: reset wins
    step(1'b1, 1'b1, 3'b111, 8'hA5);
    step(1'b1, 1'b0, 3'b000, 8'h00);
    check("reset_led", 8'h00);

    for (int i = 0; i < 25; i++) begin
      step(1'b0, 1'b1, tbl[i].btn, tbl[i].sw);
      check($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // i_valid low: buttons ignored
    step(1'b0, 1'b1, 3'b100, 8'h20);
    check("op_add_load", 8'h00);
    step(1'b0, 1'b1, 3'b000, 8'h00);
    check("add_80_01", 8'h81);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 3'b111, 8'h55);
      check($sformatf("valid_low[%0d]", i), 8'h81);
    end
    step(1'b0, 1'b1, 3'b011, 8'h07);
    check("dual_load_edge", 8'h81);
    step(1'b0, 1'b1, 3'b000, 8'h00);
    check("dual_load_add", 8'h0E);

    // reset concurrent with a load of A
    step(1'b1, 1'b1, 3'b001, 8'h09);
    check("reset_mid_op", 8'h00);
    step(1'b0, 1'b1, 3'b010, 8'h03);
    check("post_reset_b", 8'h00);
    step(1'b0, 1'b1, 3'b100, 8'h20);
    check("post_reset_op", 8'h00);
    step(1'b0, 1'b1, 3'b000, 8'h00);
    check("post_reset_add", 8'h03);

    // randomized run against the reference model
    step(1'b1, 1'b0, 3'b000, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic       v;
      logic [2:0] b;
      logic [7:0] s;
      logic [7:0] ops [10];
      ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02, 8'h3F, 8'h00};
      r = ($urandom_range(0, 63) == 0);
      v = ($urandom_range(0, 3) != 0);
      b = 3'($urandom_range(0, 7));
      s = 8'($urandom_range(0, 255));
      if (b[2] && $urandom_range(0, 3) != 0) s = ops[$urandom_range(0, 9)];
      else if (b[1] && $urandom_range(0, 2) == 0) s = 8'($urandom_range(0, 11));
      step(r, v, b, s);
      check($sformatf("random[%0d]", i), m_led);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/top_alu.md
Name: top_alu

Overview:
Board-level wrapper around a combinational 8-bit signed ALU, driven from switches and buttons. Three push-buttons capture the switch value into operand A, operand B or the opcode register. The ALU result is registered and shown on the LEDs. Top of the TP1 ALU design; connects directly to board I/O.

Parameters:
NB_DATA, 8, operand/result width in bits (two's complement)
NB_OP, 6, opcode width in bits (MIPS R-type funct encoding)

Ports:
clk  in  1  system clock; all state on rising edge
i_rst  in  1  reset, synchronous, active-high
i_valid  in  1  global load enable; button loads ignored when 0
i_btn  in  3  [0] load A, [1] load B, [2] load opcode
i_sw_data  in  NB_DATA  switch value, signed; opcode taken from bits [NB_OP-1:0]
o_led  out  NB_DATA  registered signed ALU result

Behaviour:
- Reset (i_rst=1 at a rising edge): data_a=0, data_b=0, op=0, o_led=0. Reset has priority over every load, including a load in the same cycle. Reset mid-operation discards all stored operands and the opcode.
- Loads are level-sensitive and need no edge detect. On each rising edge with i_valid=1 and no reset:
  - i_btn[0]=1 -> data_a <= i_sw_data
  - i_btn[1]=1 -> data_b <= i_sw_data
  - i_btn[2]=1 -> op <= i_sw_data[NB_OP-1:0]
  - Bits are independent. If several are set, every selected register loads the same switch value in that cycle.
  - Holding a button reloads the same value each cycle.
- i_valid=0: all three registers hold, whatever i_btn is.
- ALU (combinational, on data_a, data_b, op):
  - 100000 ADD: a+b
  - 100010 SUB: a-b
  - 100100 AND
  - 100101 OR
  - 100110 XOR
  - 100111 NOR
  - 000011 SRA: a >>> b (arithmetic)
  - 000010 SRL: a >> b (logical)
  - Any other code, including 0: result 0.
- Arithmetic wraps modulo 2^NB_DATA. No carry, overflow or zero flags.
- Shift amount is data_b read as unsigned. Amount >= NB_DATA gives 0 for SRL, and all sign bits for SRA.
- Output: o_led <= alu_result on every non-reset rising edge, regardless of i_valid.
- Latency: a register loaded at edge N appears in o_led at edge N+1. o_led then tracks the stored operands continuously.

Decomposition:
- Shared package top_alu_pkg holds:
  - NB_DATA and NB_OP defaults
  - opcode localparams OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL
- Natural sub-module: alu, purely combinational, parameterised by NB_DATA/NB_OP.
- top_alu holds the input registers, the load logic and the output register.

Test Plan:
- Reset, then valid=1. Load A=15 (btn=001), B=10 (btn=010), op=100000 -> o_led=25 one edge after the op load. Change op to 100010 -> o_led=5.
- A=15, B=10, ops AND/OR/XOR/NOR -> 10, 15, 5, -16 (0xF0).
- A=-16 (0xF0), B=2: SRA -> -4 (0xFC); SRL -> 0x3C. B=9: SRA -> -1, SRL -> 0.
- Overflow: A=127, B=1, ADD -> -128. A=-128, B=1, SUB -> 127. Undefined op 111111 -> 0.
- i_valid=0 while pulsing btn=111 with sw=0x55 -> registers and o_led unchanged. btn=011 with valid=1 and sw=7 -> A=B=7; ADD gives 14.
- Assert i_rst together with btn=001 (sw=9) mid-operation -> next edge o_led=0 and A not loaded. After reset, ADD with only B=3 loaded -> 3.
